// File: rtl/lmt_writer.sv
// lmt_writer: on each upLMT request, snapshot a free-running 64-bit cycle
// timestamp and write it as little-endian 16-bit words into the LMT region
// through an arbitrated write port. Requests arriving mid-write coalesce
// into a single pending follow-up sequence.
module lmt_writer #(
  parameter logic [15:0] LMT_BASE  = 16'h0040,
  parameter logic [15:0] LMT_SIZE  = 16'h0020,
  parameter int unsigned CNT_WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        upLMT,
  input  logic        lmt_wr_rdy,
  output logic        lmt_wr_en,
  output logic [15:0] lmt_wr_addr,
  output logic [15:0] lmt_wr_data,
  output logic        busy,
  output logic        done,
  output logic        pend
);

  localparam int unsigned TS_W  = 16 * CNT_WORDS;
  localparam int unsigned IDX_W = (CNT_WORDS > 1) ? $clog2(CNT_WORDS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CNT_WORDS - 1);

  // Refuse to build when the region cannot hold the whole timestamp.
  if (32'(LMT_SIZE) < 2 * CNT_WORDS) begin : g_size_chk
    $error("lmt_writer: LMT_SIZE smaller than 2*CNT_WORDS bytes");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [TS_W-1:0]  ts;
  logic [TS_W-1:0]  snap, snap_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             pend_nxt;
  logic             commit;
  logic [15:0]      addr_nxt;
  logic [15:0]      data_nxt;

  // Free-running timestamp; wraps silently.
  always_ff @(posedge clk) begin
    if (reset) ts <= '0;
    else       ts <= ts + TS_W'(1);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state, word index, snapshot and pending-request logic.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    snap_nxt  = snap;
    pend_nxt  = pend;
    commit    = (state == WRITE) && lmt_wr_rdy;
    case (state)
      IDLE: begin
        if (upLMT) begin
          state_nxt = WRITE;
          idx_nxt   = '0;
          // ts+1 is the counter value during the first WRITE cycle.
          snap_nxt  = ts + TS_W'(1);
        end
      end
      WRITE: begin
        if (upLMT) pend_nxt = 1'b1;
        if (commit) begin
          if (idx == IDX_LAST) state_nxt = DONE;
          else                 idx_nxt   = idx + IDX_W'(1);
        end
      end
      DONE: begin
        // A request in the DONE cycle is folded in like a pending one.
        if (pend || upLMT) begin
          state_nxt = WRITE;
          idx_nxt   = '0;
          snap_nxt  = ts + TS_W'(1);
          pend_nxt  = 1'b0;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Address and data of the word presented in the next cycle.
  always_comb begin
    addr_nxt = '0;
    data_nxt = '0;
    if (state_nxt == WRITE) begin
      addr_nxt = LMT_BASE + (16'(idx_nxt) << 1);
      for (int i = 0; i < int'(CNT_WORDS); i++) begin
        if (idx_nxt == IDX_W'(i)) data_nxt = snap_nxt[16*i +: 16];
      end
    end
  end

  // Datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      snap        <= '0;
      idx         <= '0;
      pend        <= 1'b0;
      lmt_wr_en   <= 1'b0;
      lmt_wr_addr <= '0;
      lmt_wr_data <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      snap        <= snap_nxt;
      idx         <= idx_nxt;
      pend        <= pend_nxt;
      lmt_wr_en   <= (state_nxt == WRITE);
      lmt_wr_addr <= addr_nxt;
      lmt_wr_data <= data_nxt;
      busy        <= (state_nxt != IDLE);
      done        <= (state_nxt == DONE);
    end
  end

endmodule
